fpu_out_arb: RTL and testbench

FPU output-slot arbiter and CPX credit controller. Each cycle it picks at most one of the divide, multiply and add pipes to drive the single shared FPU-to-CPX result register. It issues the one-hot `dest_rdy` select and `req_thread` to the output datapath and stalls the losing pipes. It also tracks CPX return-queue credits, so a result is only launched when the CPX can accept it.

---
 rtl/fpu_out_arb_pkg.sv | 22 ++
 rtl/fpu_out_credit.sv | 31 +++
 rtl/fpu_out_arb.sv | 150 +++++++++++++++
 tb/tb_fpu_out_arb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_out_arb_pkg.sv
// Shared FPU output-arbiter definitions: pipe indices, one-hot dest type, tid width.
package fpu_out_arb_pkg;

    localparam int unsigned FPU_TID_W = 2;
    localparam int unsigned FPU_PIPES = 3;

    localparam logic [1:0] FPU_PIPE_ADD = 2'd0;
    localparam logic [1:0] FPU_PIPE_MUL = 2'd1;
    localparam logic [1:0] FPU_PIPE_DIV = 2'd2;

    typedef logic [FPU_PIPES-1:0] fpu_dest_t;

    // Round-robin successor: add -> mul -> div -> add.
    function automatic logic [1:0] fpu_next_pipe(input logic [1:0] pipe);
        case (pipe)
            FPU_PIPE_ADD: fpu_next_pipe = FPU_PIPE_MUL;
            FPU_PIPE_MUL: fpu_next_pipe = FPU_PIPE_DIV;
            default:      fpu_next_pipe = FPU_PIPE_ADD;
        endcase
    endfunction

endpackage

// File: rtl/fpu_out_credit.sv
// CPX return-queue credit counter with saturation at CREDITS and sticky overflow error.
module fpu_out_credit #(
    parameter int unsigned CREDITS = 2
) (
    input  logic       rclk,
    input  logic       arst,
    input  logic       grant,
    input  logic       ret,
    output logic [2:0] credit_cnt,
    output logic       credit_err
);

    localparam logic [2:0] CRED_MAX = 3'(CREDITS);

    // A simultaneous grant and return cancel; a return at full is an error, not a wrap.
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            credit_cnt <= CRED_MAX;
            credit_err <= 1'b0;
        end else if (grant && !ret) begin
            credit_cnt <= credit_cnt - 3'd1;
        end else if (ret && !grant) begin
            if (credit_cnt == CRED_MAX) begin
                credit_err <= 1'b1;
            end else begin
                credit_cnt <= credit_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/fpu_out_arb.sv
// FPU output-slot arbiter: picks div/mul/add for the shared CPX result register.
// Optional FPU_OUT_RR_EN replaces fixed div>mul>add priority with round-robin.
module fpu_out_arb
    import fpu_out_arb_pkg::*;
#(
    parameter int unsigned CREDITS    = 2,
    parameter int unsigned STARVE_MAX = 7
) (
    input  logic                 rclk,
    input  logic                 arst,
    input  logic                 div_req,
    input  logic [FPU_TID_W-1:0] div_tid,
    input  logic                 mul_req,
    input  logic [FPU_TID_W-1:0] mul_tid,
    input  logic                 add_req,
    input  logic [FPU_TID_W-1:0] add_tid,
    input  logic                 cpx_credit_ret,
    output fpu_dest_t            dest_rdy,
    output logic [FPU_TID_W-1:0] req_thread,
    output logic                 div_stall,
    output logic                 mul_stall,
    output logic                 add_stall,
    output logic                 fp_cpx_req_cq,
    output logic [2:0]           credit_cnt,
    output logic                 credit_err
);

    localparam logic [3:0] WAIT_SAT  = 4'hF;
    localparam logic [3:0] STARVE_TH = 4'(STARVE_MAX);

    fpu_dest_t  req;
    fpu_dest_t  starved;
    fpu_dest_t  cand;
    logic [3:0] wait_cnt [FPU_PIPES];
    logic       credit_ok;
    logic       grant_any;

    assign req       = {div_req, mul_req, add_req};
    assign credit_ok = (credit_cnt != 3'd0);
    assign grant_any = |dest_rdy;

    // Starved requesters, if any, are the only candidates.
    always_comb begin : starve_detect
        starved = '0;
        for (int i = 0; i < int'(FPU_PIPES); i++) begin
            starved[i] = req[i] && (wait_cnt[i] >= STARVE_TH);
        end
        cand = (|starved) ? starved : req;
    end

`ifdef FPU_OUT_RR_EN
    logic [1:0] rr_ptr;

    always_comb begin : rr_pick
        logic [1:0] pipe;
        logic       found;
        dest_rdy = '0;
        found    = 1'b0;
        pipe     = fpu_next_pipe(rr_ptr);
        for (int k = 0; k < int'(FPU_PIPES); k++) begin
            if (!found && cand[pipe]) begin
                dest_rdy[pipe] = 1'b1;
                found          = 1'b1;
            end
            pipe = fpu_next_pipe(pipe);
        end
        if (arst || !credit_ok) begin
            dest_rdy = '0;
        end
    end

    always_ff @(posedge rclk or posedge arst) begin : rr_ptr_reg
        if (arst) begin
            rr_ptr <= FPU_PIPE_ADD;
        end else if (dest_rdy[FPU_PIPE_DIV]) begin
            rr_ptr <= FPU_PIPE_DIV;
        end else if (dest_rdy[FPU_PIPE_MUL]) begin
            rr_ptr <= FPU_PIPE_MUL;
        end else if (dest_rdy[FPU_PIPE_ADD]) begin
            rr_ptr <= FPU_PIPE_ADD;
        end
    end
`else
    always_comb begin : fixed_pick
        dest_rdy = '0;
        if (cand[FPU_PIPE_DIV]) begin
            dest_rdy[FPU_PIPE_DIV] = 1'b1;
        end else if (cand[FPU_PIPE_MUL]) begin
            dest_rdy[FPU_PIPE_MUL] = 1'b1;
        end else if (cand[FPU_PIPE_ADD]) begin
            dest_rdy[FPU_PIPE_ADD] = 1'b1;
        end
        if (arst || !credit_ok) begin
            dest_rdy = '0;
        end
    end
`endif

    always_comb begin : tid_mux
        req_thread = '0;
        if (dest_rdy[FPU_PIPE_DIV]) begin
            req_thread = div_tid;
        end else if (dest_rdy[FPU_PIPE_MUL]) begin
            req_thread = mul_tid;
        end else if (dest_rdy[FPU_PIPE_ADD]) begin
            req_thread = add_tid;
        end
    end

    assign div_stall = div_req & ~dest_rdy[FPU_PIPE_DIV];
    assign mul_stall = mul_req & ~dest_rdy[FPU_PIPE_MUL];
    assign add_stall = add_req & ~dest_rdy[FPU_PIPE_ADD];

    // Wait counters freeze while out of credits: nobody is losing arbitration then.
    always_ff @(posedge rclk or posedge arst) begin : wait_ctr
        if (arst) begin
            for (int i = 0; i < int'(FPU_PIPES); i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(FPU_PIPES); i++) begin
                if (!req[i] || dest_rdy[i]) begin
                    wait_cnt[i] <= '0;
                end else if (credit_ok && (wait_cnt[i] != WAIT_SAT)) begin
                    wait_cnt[i] <= wait_cnt[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge rclk or posedge arst) begin : cq_reg
        if (arst) begin
            fp_cpx_req_cq <= 1'b0;
        end else begin
            fp_cpx_req_cq <= grant_any;
        end
    end

    fpu_out_credit #(
        .CREDITS (CREDITS)
    ) u_credit (
        .rclk       (rclk),
        .arst       (arst),
        .grant      (grant_any),
        .ret        (cpx_credit_ret),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err)
    );

endmodule

// File: tb/tb_fpu_out_arb.sv
// Self-checking bench for fpu_out_arb: directed scenarios plus randomized traffic vs a reference model.
module tb_fpu_out_arb;
    import fpu_out_arb_pkg::*;

    localparam int unsigned CREDITS    = 2;
    localparam int unsigned STARVE_MAX = 3;

    logic       rclk = 1'b0;
    logic       arst = 1'b1;
    logic       div_req = 1'b0, mul_req = 1'b0, add_req = 1'b0;
    logic [1:0] div_tid = '0, mul_tid = '0, add_tid = '0;
    logic       cpx_credit_ret = 1'b0;
    fpu_dest_t  dest_rdy;
    logic [1:0] req_thread;
    logic       div_stall, mul_stall, add_stall;
    logic       fp_cpx_req_cq;
    logic [2:0] credit_cnt;
    logic       credit_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state (pipe index: 0=add, 1=mul, 2=div)
    int       m_cred;
    bit       m_err;
    int       m_wait [3];
    int       m_ptr;
    bit       m_cq;
    bit [2:0] rq;
    int       tid [3];

    fpu_out_arb #(
        .CREDITS    (CREDITS),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .rclk           (rclk),
        .arst           (arst),
        .div_req        (div_req),
        .div_tid        (div_tid),
        .mul_req        (mul_req),
        .mul_tid        (mul_tid),
        .add_req        (add_req),
        .add_tid        (add_tid),
        .cpx_credit_ret (cpx_credit_ret),
        .dest_rdy       (dest_rdy),
        .req_thread     (req_thread),
        .div_stall      (div_stall),
        .mul_stall      (mul_stall),
        .add_stall      (add_stall),
        .fp_cpx_req_cq  (fp_cpx_req_cq),
        .credit_cnt     (credit_cnt),
        .credit_err     (credit_err)
    );

    always #5 rclk = ~rclk;

    task automatic set_in(input bit d, input bit m, input bit a, input bit r);
        div_req = d; mul_req = m; add_req = a; cpx_credit_ret = r;
    endtask

    task automatic apply_reset();
        @(negedge rclk);
        arst = 1'b1;
        set_in(0, 0, 0, 0);
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        arst = 1'b0;
    endtask

    function automatic logic [2:0] model_pick();
        logic [2:0] g;
        int order [3];
        g = '0;
`ifdef FPU_OUT_RR_EN
        order[0] = (m_ptr + 1) % 3; order[1] = (m_ptr + 2) % 3; order[2] = m_ptr;
`else
        order[0] = 2; order[1] = 1; order[2] = 0;
`endif
        if (m_cred == 0) return g;
        // pass 0 considers only starved requesters, pass 1 everyone
        for (int pass = 0; pass < 2; pass++)
            for (int k = 0; k < 3; k++)
                if (g == '0 && rq[order[k]] && (pass == 1 || m_wait[order[k]] >= int'(STARVE_MAX)))
                    g[order[k]] = 1'b1;
        return g;
    endfunction

    task automatic model_tick(input logic [2:0] g, input bit ret);
        for (int i = 0; i < 3; i++) begin
            if (!rq[i] || g[i]) m_wait[i] = 0;
            else if (m_cred != 0 && m_wait[i] < 15) m_wait[i]++;
            if (g[i]) m_ptr = i;
        end
        if (g != 0 && !ret) m_cred--;
        else if (ret && g == 0) begin
            if (m_cred == int'(CREDITS)) m_err = 1'b1;
            else m_cred++;
        end
        m_cq = (g != 0);
    endtask

    task automatic test_reset();
        @(negedge rclk);
        arst = 1'b1;
        set_in(1, 0, 1, 0);
        #1;
        n_cmp++; if (dest_rdy !== 3'b000) begin n_fail++; $display("FAIL reset_dest: got %b want 000", dest_rdy); end
        n_cmp++; if ({div_stall, mul_stall, add_stall} !== 3'b101) begin n_fail++; $display("FAIL reset_stall: got %b want 101", {div_stall, mul_stall, add_stall}); end
        n_cmp++; if (credit_cnt !== 3'(CREDITS)) begin n_fail++; $display("FAIL reset_credit: got %0d want %0d", credit_cnt, CREDITS); end
        n_cmp++; if ({fp_cpx_req_cq, credit_err} !== 2'b00) begin n_fail++; $display("FAIL reset_cq_err: got %b want 00", {fp_cpx_req_cq, credit_err}); end
        apply_reset();
    endtask

    task automatic test_single_add();
        apply_reset();
        @(negedge rclk);
        set_in(0, 0, 1, 0); add_tid = 2'd2;
        #1;
        n_cmp++; if (dest_rdy !== 3'b001) begin n_fail++; $display("FAIL single_dest: got %b want 001", dest_rdy); end
        n_cmp++; if (req_thread !== 2'd2) begin n_fail++; $display("FAIL single_tid: got %0d want 2", req_thread); end
        @(negedge rclk);
        set_in(0, 0, 0, 0);
        #1;
        n_cmp++; if (fp_cpx_req_cq !== 1'b1) begin n_fail++; $display("FAIL single_cq: got %b want 1", fp_cpx_req_cq); end
        n_cmp++; if (credit_cnt !== 3'd1) begin n_fail++; $display("FAIL single_credit: got %0d want 1", credit_cnt); end
        @(negedge rclk); #1;
        n_cmp++; if (fp_cpx_req_cq !== 1'b0) begin n_fail++; $display("FAIL single_cq_drop: got %b want 0", fp_cpx_req_cq); end
    endtask

    task automatic test_credit_exhaust();
        logic [2:0] ed, es;
        apply_reset();
        div_tid = 2'd1; mul_tid = 2'd2; add_tid = 2'd3;
        for (int c = 0; c < 4; c++) begin
            @(negedge rclk);
            set_in(1, 1, 1, 0);
            #1;
            ed = (c < 2) ? 3'b100 : 3'b000;
            es = (c < 2) ? 3'b011 : 3'b111;
            n_cmp++; if (dest_rdy !== ed) begin n_fail++; $display("FAIL exhaust_dest c%0d: got %b want %b", c, dest_rdy, ed); end
            n_cmp++; if ({div_stall, mul_stall, add_stall} !== es) begin n_fail++; $display("FAIL exhaust_stall c%0d: got %b want %b", c, {div_stall, mul_stall, add_stall}, es); end
            n_cmp++; if (credit_cnt !== 3'(2 - ((c < 2) ? c : 2))) begin n_fail++; $display("FAIL exhaust_credit c%0d: got %0d want %0d", c, credit_cnt, 2 - ((c < 2) ? c : 2)); end
            n_cmp++; if (req_thread !== ((c < 2) ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL exhaust_tid c%0d: got %0d", c, req_thread); end
        end
    endtask

    task automatic test_starvation();
        logic [2:0] exp_seq [6];
        exp_seq = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b100};
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge rclk);
            set_in(1, 1, c > 0, 1);
            #1;
            n_cmp++; if (dest_rdy !== exp_seq[c]) begin n_fail++; $display("FAIL starve_dest c%0d: got %b want %b", c, dest_rdy, exp_seq[c]); end
        end
        n_cmp++; if (add_stall !== 1'b1) begin n_fail++; $display("FAIL starve_clear: add_stall got %b want 1", add_stall); end
        n_cmp++; if ({credit_cnt, credit_err} !== {3'd2, 1'b0}) begin n_fail++; $display("FAIL starve_credit: got %0d/%b want 2/0", credit_cnt, credit_err); end
    endtask

    task automatic test_rr();
        logic [2:0] exp_seq [6];
        exp_seq = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
        apply_reset();
        div_tid = 2'd1; mul_tid = 2'd2; add_tid = 2'd3;
        for (int c = 0; c < 6; c++) begin
            @(negedge rclk);
            set_in(1, 1, 1, 1);
            #1;
            n_cmp++; if (dest_rdy !== exp_seq[c]) begin n_fail++; $display("FAIL rr_dest c%0d: got %b want %b", c, dest_rdy, exp_seq[c]); end
        end
    endtask

    task automatic test_credit_ret();
        apply_reset();
        @(negedge rclk); set_in(0, 0, 1, 0);
        @(negedge rclk); set_in(0, 0, 1, 1); #1;
        n_cmp++; if (dest_rdy !== 3'b001 || credit_cnt !== 3'd1) begin n_fail++; $display("FAIL cret_setup: dest %b credit %0d want 001/1", dest_rdy, credit_cnt); end
        @(negedge rclk); set_in(0, 0, 0, 1); #1;
        n_cmp++; if (credit_cnt !== 3'd1) begin n_fail++; $display("FAIL cret_same_cycle: got %0d want 1", credit_cnt); end
        @(negedge rclk); set_in(0, 0, 0, 1); #1;
        n_cmp++; if ({credit_cnt, credit_err} !== {3'd2, 1'b0}) begin n_fail++; $display("FAIL cret_refill: got %0d/%b want 2/0", credit_cnt, credit_err); end
        @(negedge rclk); set_in(0, 0, 0, 0); #1;
        n_cmp++; if ({credit_cnt, credit_err} !== {3'd2, 1'b1}) begin n_fail++; $display("FAIL cret_overflow: got %0d/%b want 2/1", credit_cnt, credit_err); end
        @(negedge rclk); #1;
        n_cmp++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL cret_sticky: got %b want 1", credit_err); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        div_tid = 2'd1;
        repeat (2) begin @(negedge rclk); set_in(1, 0, 0, 0); end
        @(negedge rclk); #1;
        n_cmp++; if ({fp_cpx_req_cq, credit_cnt} !== {1'b1, 3'd0}) begin n_fail++; $display("FAIL rmid_pre: cq %b credit %0d want 1/0", fp_cpx_req_cq, credit_cnt); end
        arst = 1'b1; #1;
        n_cmp++; if ({fp_cpx_req_cq, credit_cnt} !== {1'b0, 3'd2}) begin n_fail++; $display("FAIL rmid_async: cq %b credit %0d want 0/2", fp_cpx_req_cq, credit_cnt); end
        n_cmp++; if (dest_rdy !== 3'b000 || div_stall !== 1'b1) begin n_fail++; $display("FAIL rmid_dest: dest %b stall %b want 000/1", dest_rdy, div_stall); end
        @(negedge rclk); arst = 1'b0; #1;
        n_cmp++; if (dest_rdy !== 3'b100 || req_thread !== 2'd1) begin n_fail++; $display("FAIL rmid_resume: dest %b tid %0d want 100/1", dest_rdy, req_thread); end
    endtask

    task automatic test_random();
        logic [2:0] g, last_g;
        logic [1:0] et;
        bit ret;
        apply_reset();
        m_cred = int'(CREDITS); m_err = 0; m_ptr = 0; m_cq = 0;
        for (int i = 0; i < 3; i++) begin m_wait[i] = 0; tid[i] = 0; end
        rq = '0; last_g = '0;
        for (int c = 0; c < 800; c++) begin
            @(negedge rclk);
            for (int i = 0; i < 3; i++) begin
                if (last_g[i]) rq[i] = 1'b0;
                if (!rq[i]) begin
                    if ($urandom_range(0, 2) == 0) begin rq[i] = 1'b1; tid[i] = int'($urandom_range(0, 3)); end
                end else if ($urandom_range(0, 15) == 0) rq[i] = 1'b0;
            end
            ret = (m_cred < int'(CREDITS)) && ($urandom_range(0, 2) == 0);
            div_tid = 2'(tid[2]); mul_tid = 2'(tid[1]); add_tid = 2'(tid[0]);
            set_in(rq[2], rq[1], rq[0], ret);
            #1;
            g  = model_pick();
            et = g[2] ? 2'(tid[2]) : g[1] ? 2'(tid[1]) : g[0] ? 2'(tid[0]) : 2'd0;
            n_cmp++; if (dest_rdy !== g) begin n_fail++; $display("FAIL rand_dest c%0d: got %b want %b", c, dest_rdy, g); end
            n_cmp++; if (req_thread !== et) begin n_fail++; $display("FAIL rand_tid c%0d: got %0d want %0d", c, req_thread, et); end
            n_cmp++; if ({div_stall, mul_stall, add_stall} !== (rq & ~g)) begin n_fail++; $display("FAIL rand_stall c%0d: got %b want %b", c, {div_stall, mul_stall, add_stall}, rq & ~g); end
            n_cmp++; if (fp_cpx_req_cq !== m_cq) begin n_fail++; $display("FAIL rand_cq c%0d: got %b want %b", c, fp_cpx_req_cq, m_cq); end
            n_cmp++; if (credit_cnt !== 3'(m_cred) || credit_err !== m_err) begin n_fail++; $display("FAIL rand_credit c%0d: got %0d/%b want %0d/%b", c, credit_cnt, credit_err, m_cred, m_err); end
            @(posedge rclk);
            model_tick(g, ret);
            last_g = g;
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
`ifdef FPU_OUT_RR_EN
        test_rr();
`else
        test_credit_exhaust();
        test_starvation();
`endif
        test_credit_ret();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
